led_display_arbiter: RTL and testbench

//  Shares one NUM-digit 7-segment display among REQ_NUM requesters (status, debug, user logic).

---
 rtl/led_arb_pkg.sv | 44 ++++
 rtl/led_rr_picker.sv | 30 +++
 rtl/led_display_arbiter.sv | 131 +++++++++++++
 tb/tb_led_display_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED display arbiter and other round-robin shared-resource arbiters.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        SWITCH
    } arb_state_t;

    localparam int MAX_REQ = 32;
    localparam int PTR_W   = 5;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [7:0] blank_byte(input logic valid_signal);
        return {8{~valid_signal}};
    endfunction

    // First set bit at or after ptr, wrapping at n; only the low n request bits are considered.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [PTR_W-1:0]   ptr,
                                         input logic [PTR_W:0]     n);
        rr_pick_t       r;
        logic [PTR_W:0] idx;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= n) idx = idx - n;
            if ((PTR_W+1)'(k) < n && !r.found && req[idx[PTR_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = idx[PTR_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_rr_picker.sv
// Combinational round-robin picker: chooses the first active request at or after ptr, wrapping.
module led_rr_picker
    import led_arb_pkg::*;
#(
    parameter int REQ_NUM = 3
) (
    input  logic [REQ_NUM-1:0]           req,
    input  logic [id_width(REQ_NUM)-1:0] ptr,
    output logic                         found,
    output logic [id_width(REQ_NUM)-1:0] idx
);

    localparam int IW = id_width(REQ_NUM);

    logic [MAX_REQ-1:0] req_ext;
    logic [PTR_W-1:0]   ptr_ext;
    rr_pick_t           pick;

    always_comb begin
        req_ext              = '0;
        req_ext[REQ_NUM-1:0] = req;
        ptr_ext              = '0;
        ptr_ext[IW-1:0]      = ptr;
        pick                 = rr_pick(req_ext, ptr_ext, (PTR_W+1)'(REQ_NUM));
    end

    assign found = pick.found;
    assign idx   = IW'(pick.idx);

endmodule

// File: rtl/led_display_arbiter.sv
// Round-robin owner of a shared NUM-digit 7-segment frame with minimum hold and blank handover.
// Optional blinking of the owner's frame is built in when LED_ARB_BLINK_EN is defined.
module led_display_arbiter
    import led_arb_pkg::*;
#(
    parameter int   NUM          = 4,
    parameter int   REQ_NUM      = 3,
    parameter logic VALID_SIGNAL = 1'b0,
    parameter int   HOLD_CYCLE   = 1000
`ifdef LED_ARB_BLINK_EN
    ,
    parameter int   BLINK_CYCLE  = 500000
`endif
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [REQ_NUM-1:0]                  req,
    input  logic [REQ_NUM-1:0][NUM-1:0][7:0]    frame_in,
`ifdef LED_ARB_BLINK_EN
    input  logic [REQ_NUM-1:0]                  blink_in,
`endif
    output logic [REQ_NUM-1:0]                  grant,
    output logic [id_width(REQ_NUM)-1:0]        owner_id,
    output logic                                busy,
    output logic [NUM-1:0][7:0]                 disp_frame
);

    localparam int OW = id_width(REQ_NUM);
    localparam int HW = (HOLD_CYCLE > 1) ? $clog2(HOLD_CYCLE) : 1;
    localparam logic [HW-1:0]         HOLD_MAX    = HW'(HOLD_CYCLE - 1);
    localparam logic [OW-1:0]         LAST_ID     = OW'(REQ_NUM - 1);
    localparam logic [NUM-1:0][7:0]   BLANK_FRAME = {NUM{blank_byte(VALID_SIGNAL)}};

    arb_state_t     state;
    logic [OW-1:0]  rr_ptr;
    logic [HW-1:0]  hold_cnt;
    logic           pick_found;
    logic [OW-1:0]  pick_idx;
    logic           owner_req;
    logic           other_req;

    led_rr_picker #(
        .REQ_NUM(REQ_NUM)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // grant is one-hot on the owner while in SHOW, so it doubles as the owner mask.
    assign owner_req = |(req & grant);
    assign other_req = |(req & ~grant);

`ifdef LED_ARB_BLINK_EN
    localparam int BW = (BLINK_CYCLE > 1) ? $clog2(BLINK_CYCLE) : 1;

    logic [BW-1:0]        blink_cnt;
    logic                 blink_ph;
    logic [NUM-1:0][7:0]  last_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_CYCLE - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            owner_id   <= '0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            busy       <= 1'b0;
            disp_frame <= BLANK_FRAME;
`ifdef LED_ARB_BLINK_EN
            last_frame <= BLANK_FRAME;
`endif
        end else begin
            case (state)
                IDLE: begin
                    disp_frame <= BLANK_FRAME;
                    busy       <= 1'b0;
                    if (pick_found) begin
                        owner_id <= pick_idx;
                        grant    <= REQ_NUM'(1) << pick_idx;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= SHOW;
`ifdef LED_ARB_BLINK_EN
                        last_frame <= BLANK_FRAME;
`endif
                    end
                end
                SHOW: begin
`ifdef LED_ARB_BLINK_EN
                    // last_frame keeps the owner's image so it can return after a blank blink phase.
                    if (owner_req) last_frame <= frame_in[owner_id];
                    if (blink_in[owner_id] && blink_ph) disp_frame <= BLANK_FRAME;
                    else if (owner_req)                 disp_frame <= frame_in[owner_id];
                    else                                disp_frame <= last_frame;
`else
                    if (owner_req) disp_frame <= frame_in[owner_id];
`endif
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (!owner_req || other_req) begin
                        grant  <= '0;
                        rr_ptr <= (owner_id == LAST_ID) ? '0 : owner_id + 1'b1;
                        state  <= SWITCH;
                    end
                end
                SWITCH: begin
                    disp_frame <= BLANK_FRAME;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Self-checking bench for led_display_arbiter: reference model compared every cycle plus directed checks.
module tb_led_display_arbiter;

    localparam int NUM         = 4;
    localparam int REQ_NUM     = 3;
    localparam int HOLD_CYCLE  = 8;
    localparam int BLINK_CYCLE = 4;
    localparam logic [31:0] BLANK = 32'hFFFFFFFF;
`ifdef LED_ARB_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic                               clk = 1'b0;
    logic                               rst;
    logic [REQ_NUM-1:0]                 req;
    logic [REQ_NUM-1:0][NUM-1:0][7:0]   frame_in;
    logic [REQ_NUM-1:0]                 blink_in;
    logic [REQ_NUM-1:0]                 grant;
    logic [1:0]                         owner_id;
    logic                               busy;
    logic [NUM-1:0][7:0]                disp_frame;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_display_arbiter #(
        .NUM          (NUM),
        .REQ_NUM      (REQ_NUM),
        .VALID_SIGNAL (1'b0),
        .HOLD_CYCLE   (HOLD_CYCLE)
`ifdef LED_ARB_BLINK_EN
        ,
        .BLINK_CYCLE  (BLINK_CYCLE)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .frame_in   (frame_in),
`ifdef LED_ARB_BLINK_EN
        .blink_in   (blink_in),
`endif
        .grant      (grant),
        .owner_id   (owner_id),
        .busy       (busy),
        .disp_frame (disp_frame)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks who owns the display, for how long, and what the screen must show.
    int          m_owner, m_last, m_age, m_phase, m_ptr, m_edges, m_cand;
    bit          m_ph, m_own_req, m_others;
    logic [31:0] m_frame, m_hold;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_last = 0; m_age = 0; m_phase = 0; m_ptr = 0; m_edges = 0;
            m_frame = BLANK; m_hold = BLANK;
        end else begin
            m_ph = BLINK_EN && (((m_edges / BLINK_CYCLE) % 2) == 1);
            m_edges++;
            case (m_phase)
                0: begin
                    m_frame = BLANK;
                    if (req != 0) begin
                        for (int k = 0; k < REQ_NUM; k++) begin
                            m_cand = (m_ptr + k) % REQ_NUM;
                            if (m_owner < 0 && req[m_cand]) m_owner = m_cand;
                        end
                        m_last  = m_owner;
                        m_age   = 1;
                        m_hold  = BLANK;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_own_req = req[m_owner];
                    m_others  = (req & ~(3'b001 << m_owner)) != 0;
                    if (m_own_req) m_hold = frame_in[m_owner];
                    m_frame = (BLINK_EN && blink_in[m_owner] && m_ph) ? BLANK : m_hold;
                    if (m_age >= HOLD_CYCLE && (!m_own_req || m_others)) begin
                        m_ptr   = (m_owner + 1) % REQ_NUM;
                        m_owner = -1;
                        m_phase = 2;
                    end else begin
                        m_age++;
                    end
                end
                default: begin
                    m_frame = BLANK;
                    m_phase = 0;
                end
            endcase
        end
    end

    logic [2:0] exp_grant;
    always @(negedge clk) begin
        if (!rst) begin
            exp_grant = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
            checkOutput("model_grant", grant, exp_grant);
            checkOutput("model_owner_id", owner_id, m_last);
            checkOutput("model_busy", busy, m_phase != 0);
            checkOutput("model_disp_frame", disp_frame, m_frame);
        end
    end

    task automatic applyStimulus(input logic [2:0] r, input logic [31:0] f0, input logic [31:0] f1,
                                 input logic [31:0] f2);
        @(posedge clk);
        #2;
        req         = r;
        frame_in[0] = f0;
        frame_in[1] = f1;
        frame_in[2] = f2;
    endtask

    task automatic doReset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic observeOwner(input int exp_owner, output int gap);
        int len;
        gap = 0;
        len = 0;
        while (grant == 0 && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        checkOutput("grant_arrived", grant != 0, 1'b1);
        checkOutput("grant_owner_id", owner_id, exp_owner);
        checkOutput("grant_onehot", grant, 3'b001 << exp_owner);
        while (grant != 0 && len < 100) begin
            @(negedge clk);
            len++;
        end
        checkOutput("grant_len", len, HOLD_CYCLE);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gap, len, nb, nf, wait_n;
        rst      = 1'b1;
        req      = '0;
        frame_in = '0;
        blink_in = '0;

        // 1: idle after reset
        doReset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_frame", disp_frame, BLANK);
            checkOutput("idle_grant", grant, 3'b000);
            checkOutput("idle_busy", busy, 1'b0);
        end

        // 2: single requester, latency and indefinite hold
        applyStimulus(3'b010, 32'h01020304, 32'hAA55AA55, 32'h0A0B0C0D);
        @(posedge clk); #1;
        checkOutput("t2_grant_1edge", grant, 3'b010);
        checkOutput("t2_owner_1edge", owner_id, 2'd1);
        checkOutput("t2_frame_1edge", disp_frame, BLANK);
        @(posedge clk); #1;
        checkOutput("t2_frame_2edge", disp_frame, 32'hAA55AA55);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("t2_grant_held", grant, 3'b010);
        checkOutput("t2_frame_held", disp_frame, 32'hAA55AA55);
        applyStimulus(3'b000, 32'h01020304, 32'hAA55AA55, 32'h0A0B0C0D);
        repeat (4) @(posedge clk);

        // 3: all request, round-robin 0,1,2,0 with 8-cycle grants and 2-cycle gaps
        doReset();
        applyStimulus(3'b111, 32'h11111111, 32'h22222222, 32'h33333333);
        observeOwner(0, gap);
        for (int i = 1; i <= 3; i++) begin
            observeOwner(i % 3, gap);
            checkOutput("t3_gap", gap, 2);
        end
        applyStimulus(3'b000, 32'h11111111, 32'h22222222, 32'h33333333);
        repeat (4) @(posedge clk);

        // 4: owner drops request early; hold still full length, frame frozen
        doReset();
        applyStimulus(3'b001, 32'h12345678, 32'h0, 32'h0);
        @(posedge clk); #1;
        checkOutput("t4_grant", grant, 3'b001);
        @(posedge clk); #2;
        req         = 3'b000;
        frame_in[0] = 32'h87654321;
        @(posedge clk); #1;
        checkOutput("t4_frozen", disp_frame, 32'h12345678);
        len = 2;
        do begin
            @(negedge clk);
            if (grant != 0) len++;
        end while (grant != 0 && len < 100);
        checkOutput("t4_grant_len", len, HOLD_CYCLE);
        @(posedge clk); #1;
        checkOutput("t4_idle_busy", busy, 1'b0);
        checkOutput("t4_idle_frame", disp_frame, BLANK);

        // 5: reset during owner 1's show; fresh arbitration starts from pointer 0
        doReset();
        applyStimulus(3'b011, 32'h44444444, 32'h55555555, 32'h66666666);
        observeOwner(0, gap);
        wait_n = 0;
        while (grant == 0 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        checkOutput("t5_owner1", grant, 3'b010);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        req = 3'b101;
        #1;
        checkOutput("t5_rst_grant", grant, 3'b000);
        checkOutput("t5_rst_frame", disp_frame, BLANK);
        checkOutput("t5_rst_busy", busy, 1'b0);
        checkOutput("t5_rst_owner", owner_id, 2'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        observeOwner(0, gap);
        applyStimulus(3'b000, 32'h44444444, 32'h55555555, 32'h66666666);
        repeat (4) @(posedge clk);

`ifdef LED_ARB_BLINK_EN
        // 6: blinking owner alternates frame and blank every BLINK_CYCLE cycles
        doReset();
        blink_in = 3'b001;
        applyStimulus(3'b001, 32'h9ABCDEF0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        nb = 0;
        nf = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (disp_frame == BLANK) nb++;
            if (disp_frame == 32'h9ABCDEF0) nf++;
            checkOutput("t6_grant", grant, 3'b001);
        end
        checkOutput("t6_blank_cycles", nb, 8);
        checkOutput("t6_frame_cycles", nf, 8);
        blink_in = 3'b000;
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
